serial_addsub: RTL
==================

Name: serial_addsub

Overview:
Parametrised bit/digit-serial adder-subtractor, successor to the 8-bit serial adder.
- Loads two WIDTH-bit operands on a start request.
- Processes DIGIT bits per clock, LSB first, through a DIGIT-bit ripple slice with a registered carry between slices.
- Reports sum/difference, unsigned carry/borrow and signed overflow with a one-cycle done pulse.
- Used as a low-area arithmetic unit in the datapath where latency is traded for gate count.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2 and an integer multiple of DIGIT.
- DIGIT, 1, bits processed per clock; N = WIDTH/DIGIT steps per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = add (A+B+cin), 1 = subtract (A−B); sampled with start.
- cin  input  1  carry-in for add mode; ignored in subtract mode.
- a_in  input  WIDTH  operand A, sampled with start.
- b_in  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result/cout/ovf valid.
- result  output  WIDTH  sum or difference, two's complement.
- cout  output  1  carry out of MSB. In subtract mode: 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Synchronous reset (rst=1 at an edge):
  - State → IDLE; busy, done, result, cout, ovf → 0.
  - Operand registers, carry and step counter → 0.
  - Applies from any state, including mid-RUN. The aborted operation produces no done.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - A register ← a_in; B register ← (mode ? ~b_in : b_in).
  - carry ← (mode ? 1 : cin); result ← 0; counter ← 0; state → RUN.
  - cout/ovf hold their previous values until the new done.
- IDLE, start=0: hold. result/cout/ovf retain the last completed operation.
- RUN, each edge:
  - Low DIGIT bits of A, B and carry feed the DIGIT-bit adder slice.
  - A and B shift right by DIGIT.
  - result shifts right by DIGIT; the slice sum enters the top DIGIT bits.
  - carry ← slice carry-out; counter increments.
- On the step where counter = N−1:
  - cout ← slice carry-out.
  - ovf ← carry into slice MSB XOR slice carry-out.
  - state → DONE.
- DONE: done=1 for exactly this one cycle; the next edge → IDLE unconditionally.
- Latency:
  - start accepted at edge 0; busy=1 after edges 0..N−1 (N cycles).
  - done=1 after edge N. Next start accepted at edge N+2 at the earliest (from IDLE).
- start during RUN or DONE is ignored, not queued. Operand inputs are don't-care outside the start sample.
- mode and cin changes during RUN have no effect.
- Carry register is fully internal; no inter-operation carry persists.
- No arithmetic wrap logic beyond modulo 2^WIDTH: result is the low WIDTH bits of the true sum.

Test Plan:
- WIDTH=8, DIGIT=1: add 0x35+0x2A, cin=0 → result=0x5F, cout=0, ovf=0; busy high 8 cycles; done single pulse after edge 8.
- Add boundaries:
  - 0xFF+0x01, cin=0 → result=0x00, cout=1, ovf=0.
  - 0x7F+0x01 → result=0x80, cout=0, ovf=1.
  - 0xFE+0x00, cin=1 → 0xFF, cout=0.
- Subtract:
  - 0x10−0x20 → result=0xF0, cout=0, ovf=0.
  - 0x80−0x01 → result=0x7F, cout=1, ovf=1.
  - 0x55−0x55 → 0x00, cout=1, ovf=0.
- Handshake:
  - start held high throughout: operations accepted only from IDLE, one every N+2 cycles, each with exactly one done.
  - start pulsed at cycle 3 of RUN and in DONE → ignored; result of the first op unchanged.
- Reset at RUN step 4 → same-edge busy=0, result=0, cout=0, ovf=0, no done. A following add 0x01+0x02 → 0x03 with correct timing.
- WIDTH=16, DIGIT=4: add 0x1234+0x0FCD → result=0x2201, cout=0, ovf=0; done after edge 4. Subtract 0x0000−0x0001 → 0xFFFF, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per clock LSB first,
// with registered inter-slice carry and unsigned carry / signed overflow flags.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT:0]   slice;
    logic             c_msb;

    always_comb begin
        slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // carry into the slice MSB recovered from its sum bit: s = a ^ b ^ c
        c_msb    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                a_d      = a_in;
                b_d      = mode ? ~b_in : b_in;
                carry_d  = mode ? 1'b1 : cin;
                result_d = '0;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                result_d = (result_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d  = slice[DIGIT];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = slice[DIGIT];
                    ovf_d   = c_msb ^ slice[DIGIT];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = state_q == RUN;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
endmodule
